primogen_seeded: RTL and testbench
==================================

// Module: primogen_seeded
// PURPOSE
//   Parametrised prime search engine, next generation of our prime generator.
//   - Searches up or down from the last result, or from a loaded seed.
//   - Contains its own bit-serial restoring modulo unit; no external divider.
//   - Sits behind a go/ready handshake.
// PARAMETERS
//   WIDTH_LOG  4  log2 of datapath width; WIDTH = 1 << WIDTH_LOG (16 by default)
// PORTS
//   clk    in   1      clock, all state on posedge
//   rst    in   1      reset, asynchronous, active-low
//   go     in   1      start search; sampled only while ready=1
//   load   in   1      with go: search starts at from (inclusive)
//   from   in   WIDTH  seed value, sampled with go&load
//   dir    in   1      sampled with go: 0 = search upward, 1 = search downward
//   ready  out  1      idle, res/error valid
//   error  out  1      last search failed (no prime in range)
//   res    out  WIDTH  last prime found
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, ready=1, error=0, res=1, internal regs 0.
// - Go accepted only when ready=1; go while busy is ignored.
// - Cycle after acceptance: ready=0, error=0.
// - Start candidate c:
//   - load=1: c = from.
//   - load=0, dir=0: c = res+1.
//   - load=0, dir=1: c = res-1.
// - Up search, c<2: c=2.
// - Down search, c<2: immediate ERROR.
// - States:
//   - IDLE -> CHECK on accepted go. Init div=2, div_sq=4; div_sq is WIDTH+1 bits and never overflows.
//   - CHECK:
//     - div_sq > c: res <= c, go to IDLE (ready=1).
//     - Otherwise go to MOD.
//   - MOD: restoring remainder of c/div, one quotient bit per cycle, exactly WIDTH cycles, then INSPECT.
//   - INSPECT:
//     - remainder==0: next candidate (c+step up, c-step down), reset div/div_sq, go to CHECK.
//     - remainder!=0: advance div and div_sq incrementally (no multiplier), go to CHECK.
//   - ERROR: ready=1, error=1, res holds last good prime.
// - Error conditions:
//   - Candidate wraps past 2^WIDTH-1 (up).
//   - Candidate drops below 2 (down).
// - Go from ERROR behaves as from IDLE, including load=0 (continues from res).
// - Latency per trial divisor: WIDTH+2 cycles. Candidate 2 or 3: 1 cycle CHECK only.
// - ready/error/res are registered; they change only on the cycle of entering IDLE/ERROR.
// - res never changes while ready=0 except on the final transition.
// - Reset mid-search: aborts immediately; outputs return to reset values.
// - Unreachable state encodings: transition to ERROR.
// CONFIGURATION
//   PRIMOGEN_WHEEL_EN defined:
//     - Candidate step is 2 after any odd candidate.
//       - Even start candidate > 2: adjusted +1 (up) or -1 (down) before the first CHECK.
//     - Divisor sequence is 2, 3, 5, 7, ... (step 2 after 3); div_sq += 4*div+4.
//   Not defined:
//     - Candidate step 1; divisor step 1; div_sq += 2*div+1.
//   Results and error outcomes are identical in both builds; only cycle counts differ.
// TESTING (WIDTH_LOG=4)
//   1. Reset, then 5x go (dir=0, load=0) -> res = 2, 3, 5, 7, 11; error=0 throughout.
//   2. go, load=1, from=100, dir=0 -> res=101.
//      Then go, load=1, from=97 -> res=97 (inclusive seed).
//   3. From res=101: go, load=0, dir=1 -> res=97.
//      Then go, load=1, from=1, dir=1 -> error=1, ready=1, res=97.
//   4. go, load=1, from=65522, dir=0 -> error=1, res unchanged.
//      Then go, load=1, from=65500 -> res=65519, error=0.
//   5. go asserted every cycle while busy -> exactly one search, one result.
//      rst=0 pulse mid-MOD -> ready=1, error=0, res=1 asynchronously.
//   6. Cycle count from go to ready for from=25 (up) matches WIDTH+2 per divisor tried.
//      Check in both PRIMOGEN_WHEEL_EN builds; results must be identical.

Source files
------------

// File: rtl/primogen_seeded_if.sv
// Handshake/result bundle for primogen_seeded: go/load/from/dir towards the engine,
// ready/error/res back from it.
interface primogen_seeded_if #(
   parameter int WIDTH = 16
) ();
   logic             go;
   logic             load;
   logic             dir;
   logic [WIDTH-1:0] from;
   logic             ready;
   logic             error;
   logic [WIDTH-1:0] res;

   modport master (output go, load, from, dir, input ready, error, res);
   modport slave  (input go, load, from, dir, output ready, error, res);
endinterface

// File: rtl/primogen_seeded.sv
// Seeded prime search engine: trial division with a bit-serial restoring modulo unit.
// Optional build macro PRIMOGEN_WHEEL_EN skips even candidates and even divisors above 2.
module primogen_seeded #(
   parameter int WIDTH_LOG = 4
) (
   input  logic          clk,
   input  logic          rst,
   primogen_seeded_if.slave bus
);
   localparam int WIDTH = 1 << WIDTH_LOG;
   localparam logic [WIDTH-1:0]   ONE      = WIDTH'(1);
   localparam logic [WIDTH-1:0]   TWO      = WIDTH'(2);
   localparam logic [WIDTH:0]     TWO_W    = (WIDTH+1)'(2);
   localparam logic [WIDTH:0]     FOUR_W   = (WIDTH+1)'(4);
   localparam logic [WIDTH_LOG:0] CNT_LAST = (WIDTH_LOG+1)'(WIDTH-1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CHECK   = 3'd1,
      S_MOD     = 3'd2,
      S_INSPECT = 3'd3,
      S_ERROR   = 3'd4
   } state_t;

   state_t             state_r, state_s;
   logic [WIDTH-1:0]   cand_r, cand_s, div_r, div_s, shift_r, shift_s, res_r, res_s;
   logic [WIDTH:0]     div_sq_r, div_sq_s, rem_r, rem_s;
   logic [WIDTH_LOG:0] cnt_r, cnt_s;
   logic               dir_r, dir_s, ready_r, ready_s, error_r, error_s;

   logic [WIDTH-1:0]   base_s, start_s, step_s, next_cand_s, div_next_s;
   logic [WIDTH:0]     up_sum_s, rem_trial_s, div_sq_next_s;
   logic               start_err_s, cand_err_s;

   // Start candidate for an accepted go: clamp, reject, and wheel-align
   always_comb begin
      start_err_s = 1'b0;
      if (bus.load) begin
         base_s = bus.from;
      end else if (bus.dir) begin
         base_s = res_r - ONE;
      end else begin
         base_s = res_r + ONE;
      end
      start_s = base_s;
      if (base_s < TWO) begin
         if (bus.dir) begin
            start_err_s = 1'b1;
         end else begin
            start_s = TWO;
         end
      end else begin
`ifdef PRIMOGEN_WHEEL_EN
         if (!base_s[0] && (base_s != TWO)) begin
            start_s = bus.dir ? (base_s - ONE) : (base_s + ONE);
         end else begin
            start_s = base_s;
         end
`else
         start_s = base_s;
`endif
      end
   end

   // Candidate and divisor stepping; div_sq tracks div*div without a multiplier
   always_comb begin
`ifdef PRIMOGEN_WHEEL_EN
      step_s = cand_r[0] ? TWO : ONE;
      if (div_r == TWO) begin
         div_next_s    = div_r + ONE;
         div_sq_next_s = (WIDTH+1)'(9);
      end else begin
         div_next_s    = div_r + TWO;
         div_sq_next_s = div_sq_r + (WIDTH+1)'({div_r, 2'b00}) + FOUR_W;
      end
`else
      step_s        = ONE;
      div_next_s    = div_r + ONE;
      div_sq_next_s = div_sq_r + (WIDTH+1)'({div_r, 1'b0}) + (WIDTH+1)'(1);
`endif
      up_sum_s = {1'b0, cand_r} + {1'b0, step_s};
      if (dir_r) begin
         next_cand_s = cand_r - step_s;
         cand_err_s  = ({1'b0, cand_r} < ({1'b0, step_s} + TWO_W));
      end else begin
         next_cand_s = up_sum_s[WIDTH-1:0];
         cand_err_s  = up_sum_s[WIDTH];
      end
      rem_trial_s = {rem_r[WIDTH-1:0], shift_r[WIDTH-1]};
   end

   // Next-state and datapath updates
   always_comb begin
      state_s  = state_r;
      cand_s   = cand_r;
      div_s    = div_r;
      div_sq_s = div_sq_r;
      rem_s    = rem_r;
      shift_s  = shift_r;
      cnt_s    = cnt_r;
      dir_s    = dir_r;
      res_s    = res_r;
      ready_s  = ready_r;
      error_s  = error_r;
      case (state_r)
         S_IDLE, S_ERROR: begin
            if (bus.go) begin
               dir_s    = bus.dir;
               div_s    = TWO;
               div_sq_s = FOUR_W;
               if (start_err_s) begin
                  state_s = S_ERROR;
                  ready_s = 1'b1;
                  error_s = 1'b1;
               end else begin
                  state_s = S_CHECK;
                  cand_s  = start_s;
                  ready_s = 1'b0;
                  error_s = 1'b0;
               end
            end else begin
               state_s = state_r;
            end
         end
         S_CHECK: begin
            if (div_sq_r > {1'b0, cand_r}) begin
               state_s = S_IDLE;
               res_s   = cand_r;
               ready_s = 1'b1;
            end else begin
               state_s = S_MOD;
               rem_s   = '0;
               shift_s = cand_r;
               cnt_s   = '0;
            end
         end
         S_MOD: begin
            // One restoring step per cycle, dividend bits taken MSB first
            if (rem_trial_s >= {1'b0, div_r}) begin
               rem_s = rem_trial_s - {1'b0, div_r};
            end else begin
               rem_s = rem_trial_s;
            end
            shift_s = {shift_r[WIDTH-2:0], 1'b0};
            cnt_s   = cnt_r + (WIDTH_LOG+1)'(1);
            if (cnt_r == CNT_LAST) begin
               state_s = S_INSPECT;
            end else begin
               state_s = S_MOD;
            end
         end
         S_INSPECT: begin
            if (rem_r == '0) begin
               div_s    = TWO;
               div_sq_s = FOUR_W;
               if (cand_err_s) begin
                  state_s = S_ERROR;
                  ready_s = 1'b1;
                  error_s = 1'b1;
               end else begin
                  state_s = S_CHECK;
                  cand_s  = next_cand_s;
               end
            end else begin
               state_s  = S_CHECK;
               div_s    = div_next_s;
               div_sq_s = div_sq_next_s;
            end
         end
         default: begin
            state_s = S_ERROR;
            ready_s = 1'b1;
            error_s = 1'b1;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= S_IDLE;
         cand_r   <= '0;
         div_r    <= '0;
         div_sq_r <= '0;
         rem_r    <= '0;
         shift_r  <= '0;
         cnt_r    <= '0;
         dir_r    <= 1'b0;
         res_r    <= ONE;
         ready_r  <= 1'b1;
         error_r  <= 1'b0;
      end else begin
         state_r  <= state_s;
         cand_r   <= cand_s;
         div_r    <= div_s;
         div_sq_r <= div_sq_s;
         rem_r    <= rem_s;
         shift_r  <= shift_s;
         cnt_r    <= cnt_s;
         dir_r    <= dir_s;
         res_r    <= res_s;
         ready_r  <= ready_s;
         error_r  <= error_s;
      end
   end

   assign bus.ready = ready_r;
   assign bus.error = error_r;
   assign bus.res   = res_r;
endmodule

// File: tb/tb_primogen_seeded.sv
// Directed self-checking bench for primogen_seeded (WIDTH_LOG=4), valid in both
// PRIMOGEN_WHEEL_EN builds; only the expected cycle count differs.
module tb_primogen_seeded;
   localparam int WIDTH_LOG = 4;
   localparam int WIDTH     = 16;
   localparam int BUDGET    = 20000;
`ifdef PRIMOGEN_WHEEL_EN
   localparam int EXP_CYC25 = 145;
`else
   localparam int EXP_CYC25 = 217;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fails  = 0;
   int   cyc;

   primogen_seeded_if #(.WIDTH(WIDTH)) bus ();
   primogen_seeded #(.WIDTH_LOG(WIDTH_LOG)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Issue one go and wait (bounded) until ready returns; cycles counted from the accepting edge
   task automatic run_search(input logic ld, input logic [15:0] fr, input logic dr, output int cycles);
      bus.go   = 1'b1;
      bus.load = ld;
      bus.from = fr;
      bus.dir  = dr;
      @(posedge clk); #1;
      bus.go   = 1'b0;
      bus.load = 1'b0;
      cycles   = 0;
      do begin
         @(posedge clk); #1;
         cycles++;
      end while (!bus.ready && cycles < BUDGET);
      check_val("search_done", 32'(bus.ready), 32'd1);
   endtask

   initial begin
      logic [15:0] primes [5];
      primes = '{16'd2, 16'd3, 16'd5, 16'd7, 16'd11};
      rst = 1'b0;
      bus.go = 1'b0; bus.load = 1'b0; bus.from = 16'd0; bus.dir = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_ready", 32'(bus.ready), 32'd1);
      check_val("rst_error", 32'(bus.error), 32'd0);
      check_val("rst_res",   32'(bus.res),   32'd1);
      rst = 1'b1;
      @(posedge clk); #1;

      // first primes upward from reset
      for (int i = 0; i < 5; i++) begin
         run_search(1'b0, 16'd0, 1'b0, cyc);
         check_val("seq_res", 32'(bus.res), 32'(primes[i]));
         check_val("seq_err", 32'(bus.error), 32'd0);
      end

      run_search(1'b1, 16'd100, 1'b0, cyc);
      check_val("seed100", 32'(bus.res), 32'd101);
      run_search(1'b1, 16'd97, 1'b0, cyc);
      check_val("seed97_incl", 32'(bus.res), 32'd97);

      run_search(1'b1, 16'd101, 1'b0, cyc);
      check_val("seed101", 32'(bus.res), 32'd101);
      run_search(1'b0, 16'd0, 1'b1, cyc);
      check_val("down_res", 32'(bus.res), 32'd97);
      run_search(1'b1, 16'd1, 1'b1, cyc);
      check_val("down_err", 32'(bus.error), 32'd1);
      check_val("down_err_res", 32'(bus.res), 32'd97);
      run_search(1'b0, 16'd0, 1'b0, cyc);
      check_val("from_err_res", 32'(bus.res), 32'd101);
      check_val("from_err_err", 32'(bus.error), 32'd0);

      run_search(1'b1, 16'd65522, 1'b0, cyc);
      check_val("wrap_err", 32'(bus.error), 32'd1);
      check_val("wrap_res", 32'(bus.res), 32'd101);
      run_search(1'b1, 16'd65500, 1'b0, cyc);
      check_val("top_res", 32'(bus.res), 32'd65519);
      check_val("top_err", 32'(bus.error), 32'd0);

      // go held high throughout; a new seed while busy must be ignored
      bus.go = 1'b1; bus.load = 1'b1; bus.from = 16'd100; bus.dir = 1'b0;
      @(posedge clk); #1;
      check_val("busy_ready", 32'(bus.ready), 32'd0);
      bus.from = 16'd200;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!bus.ready && cyc < BUDGET);
      bus.go = 1'b0; bus.load = 1'b0;
      check_val("hold_done", 32'(bus.ready), 32'd1);
      check_val("hold_res", 32'(bus.res), 32'd101);
      @(posedge clk); #1;
      check_val("hold_single", 32'(bus.ready), 32'd1);

      // asynchronous reset in the middle of a modulo pass
      bus.go = 1'b1; bus.load = 1'b1; bus.from = 16'd65500; bus.dir = 1'b0;
      @(posedge clk); #1;
      bus.go = 1'b0; bus.load = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      check_val("mid_busy", 32'(bus.ready), 32'd0);
      rst = 1'b0;
      #1;
      check_val("arst_ready", 32'(bus.ready), 32'd1);
      check_val("arst_error", 32'(bus.error), 32'd0);
      check_val("arst_res",   32'(bus.res),   32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      run_search(1'b0, 16'd0, 1'b0, cyc);
      check_val("two_res", 32'(bus.res), 32'd2);
      check_val("two_cycles", 32'(cyc), 32'd1);
      run_search(1'b1, 16'd25, 1'b0, cyc);
      check_val("c25_res", 32'(bus.res), 32'd29);
      check_val("c25_cycles", 32'(cyc), 32'(EXP_CYC25));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end
endmodule
